// File: rtl/spi_capture_pkg.sv
// rtl/spi_capture_pkg.sv - shared opcodes, FSM states and status bit positions
//
// Purpose: definitions shared by the SPI capture slave and its helpers.
// Ports:   none (package).

package spi_capture_pkg;

  // Command byte opcodes (first byte of every frame)
  localparam logic [7:0] CMD_NOP       = 8'h00;
  localparam logic [7:0] CMD_CAP_START = 8'h01;
  localparam logic [7:0] CMD_CAP_STOP  = 8'h02;
  localparam logic [7:0] CMD_STREAM    = 8'h03;
  localparam logic [7:0] CMD_WR_CFG    = 8'h04;
  localparam logic [7:0] CMD_RD_STAT   = 8'h05;

  // Frame FSM; every frame starts in ST_CMD
  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_CFG_RX  = 3'd1,
    ST_STAT_TX = 3'd2,
    ST_STREAM  = 3'd3,
    ST_IGNORE  = 3'd4
  } spi_state_t;

  // Bit positions inside status byte 0
  localparam int STAT_BUSY_BIT     = 7;
  localparam int STAT_UNDERRUN_BIT = 6;
  localparam int STAT_RD_VALID_BIT = 5;

endpackage

// File: rtl/spi_shift_byte.sv
// rtl/spi_shift_byte.sv - SPI mode 0 byte shifter with bit counter and tx load
//
// Purpose: assembles MSB-first bytes from mosi and shifts a tx byte out on miso.
// Ports:
//   sclk       SPI clock, all state on rising edge
//   reset_n    async active-low clear (the top feeds a frame reset here)
//   mosi       serial input, sampled on rising sclk
//   load       replace the tx register with load_data on this edge
//   load_data  parallel tx byte
//   byte_done  high during the cycle whose rising edge completes a byte
//   rx_byte    the byte being completed (valid when byte_done is high)
//   tx_bit     current tx MSB, drives miso

module spi_shift_byte (
  input  logic       sclk,
  input  logic       reset_n,
  input  logic       mosi,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       tx_bit
);

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;

  // Decisions are taken on the edge that samples bit 0, so the completed byte
  // is formed from the seven bits already held plus the live mosi bit.
  assign byte_done = (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi};
  assign tx_bit    = tx_sr[7];

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sr   <= {rx_sr[5:0], mosi};
      if (load) begin
        tx_sr <= load_data;
      end else begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_capture_slave.sv
// rtl/spi_capture_slave.sv - SPI mode 0 slave controlling a capture engine
//
// Purpose: decodes a command byte per frame, accepts channel/length config,
//          returns status and streams captured words with a prefetch handshake.
// Ports:
//   sclk, reset_n  SPI clock (rising edge) and async active-low reset
//   cs_n           chip select, high clears all frame state asynchronously
//   mosi, miso     serial data in / out, MSB first
//   cap_start      one-sclk pulse on a decoded CAP_START command
//   cap_stop       one-sclk pulse on a decoded CAP_STOP command
//   ch_mask        channel enable configuration
//   cap_len        capture length in words
//   rd_req         one-sclk pulse requesting the next stream word
//   rd_word        stream word from upstream, qualified by rd_valid
//   busy           capture engine running, reported in status
//   underrun       sticky: a stream load found rd_valid low

module spi_capture_slave
  import spi_capture_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int NUM_CH     = 6,
  parameter int LEN_BYTES  = 3
) (
  input  logic                      sclk,
  input  logic                      reset_n,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      cap_start,
  output logic                      cap_stop,
  output logic [NUM_CH-1:0]         ch_mask,
  output logic [8*LEN_BYTES-1:0]    cap_len,
  output logic                      rd_req,
  input  logic [8*WORD_BYTES-1:0]   rd_word,
  input  logic                      rd_valid,
  input  logic                      busy,
  output logic                      underrun
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int LEN_W  = 8 * LEN_BYTES;

  // Frame logic is held in reset whenever the chip is deselected.
  logic frame_rst_n;
  assign frame_rst_n = reset_n & ~cs_n;

  // Shifter interface
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_data;

  // Frame state
  spi_state_t        state_q, state_d;
  logic [3:0]        byte_cnt;
  logic [2:0]        wbyte, wbyte_d;
  logic [WORD_W-1:0] word_buf, word_d;
  logic [NUM_CH-1:0] mask_sh;
  logic [LEN_W-1:0]  len_sh, len_next;

  // Decoded per-edge actions
  logic start_d, stop_d, req_d;
  logic ur_set, ur_clr;
  logic cfg_commit, mask_cap, len_shift;
  logic word_boundary;

  logic [7:0] stat0, mask8;

  spi_shift_byte u_shift (
    .sclk      (sclk),
    .reset_n   (frame_rst_n),
    .mosi      (mosi),
    .load      (tx_load),
    .load_data (tx_data),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .tx_bit    (miso)
  );

  always_comb begin
    stat0                    = '0;
    stat0[STAT_BUSY_BIT]     = busy;
    stat0[STAT_UNDERRUN_BIT] = underrun;
    stat0[STAT_RD_VALID_BIT] = rd_valid;
  end

  assign mask8    = 8'(ch_mask);
  assign len_next = (len_sh << 8) | LEN_W'(rx_byte);

  // Status byte idx: 0 status, 1 mask, then cap_len MSB first, then zeros.
  function automatic logic [7:0] stat_byte(input logic [4:0]       idx,
                                           input logic [7:0]       s0,
                                           input logic [7:0]       m8,
                                           input logic [LEN_W-1:0] len);
    logic [7:0] r;
    r = '0;
    if (idx == 5'd0) begin
      r = s0;
    end else if (idx == 5'd1) begin
      r = m8;
    end else begin
      for (int k = 0; k < LEN_BYTES; k++) begin
        if (idx == 5'(k + 2)) begin
          r = len[8*(LEN_BYTES-1-k) +: 8];
        end
      end
    end
    return r;
  endfunction

  // Byte idx of a buffered stream word, 0 = MSB byte.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                           input logic [3:0]        idx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx == 4'(i)) begin
        r = w[8*(WORD_BYTES-1-i) +: 8];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    tx_load       = 1'b0;
    tx_data       = '0;
    start_d       = 1'b0;
    stop_d        = 1'b0;
    req_d         = 1'b0;
    ur_set        = 1'b0;
    ur_clr        = 1'b0;
    cfg_commit    = 1'b0;
    mask_cap      = 1'b0;
    len_shift     = 1'b0;
    word_boundary = 1'b0;
    word_d        = word_buf;
    wbyte_d       = wbyte;

    case (state_q)
      ST_CMD: begin
        if (byte_done) begin
          case (rx_byte)
            CMD_NOP: state_d = ST_IGNORE;
            CMD_CAP_START: begin
              start_d = 1'b1;
              state_d = ST_IGNORE;
            end
            CMD_CAP_STOP: begin
              stop_d  = 1'b1;
              state_d = ST_IGNORE;
            end
            CMD_STREAM: begin
              state_d       = ST_STREAM;
              word_boundary = 1'b1;
            end
            CMD_WR_CFG: state_d = ST_CFG_RX;
            CMD_RD_STAT: begin
              state_d = ST_STAT_TX;
              tx_load = 1'b1;
              tx_data = stat_byte(5'd0, stat0, mask8, cap_len);
            end
            default: state_d = ST_IGNORE;
          endcase
        end
      end

      ST_CFG_RX: begin
        if (byte_done) begin
          if (byte_cnt == 4'd0) begin
            mask_cap = 1'b1;
          end else if (byte_cnt <= 4'(LEN_BYTES)) begin
            len_shift = 1'b1;
          end
          // Config becomes visible only once the whole record has arrived.
          if (byte_cnt == 4'(LEN_BYTES)) begin
            cfg_commit = 1'b1;
          end
        end
      end

      ST_STAT_TX: begin
        if (byte_done) begin
          tx_load = 1'b1;
          tx_data = stat_byte({1'b0, byte_cnt} + 5'd1, stat0, mask8, cap_len);
          if (byte_cnt == 4'd0) begin
            ur_clr = 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (byte_done) begin
          if (wbyte == 3'(WORD_BYTES - 1)) begin
            word_boundary = 1'b1;
          end else begin
            wbyte_d = wbyte + 3'd1;
            tx_load = 1'b1;
            tx_data = word_byte(word_buf, {1'b0, wbyte} + 4'd1);
          end
        end
      end

      default: ;
    endcase

    // Word load: the request for the next word goes out on the same edge the
    // current one is taken, giving upstream a full word time to refill.
    if (word_boundary) begin
      tx_load = 1'b1;
      wbyte_d = '0;
      if (rd_valid) begin
        word_d = rd_word;
        req_d  = 1'b1;
      end else begin
        word_d = '1;
        ur_set = 1'b1;
      end
      tx_data = word_d[WORD_W-1 -: 8];
    end
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q   <= ST_CMD;
      byte_cnt  <= '0;
      wbyte     <= '0;
      word_buf  <= '0;
      mask_sh   <= '0;
      len_sh    <= '0;
      cap_start <= 1'b0;
      cap_stop  <= 1'b0;
      rd_req    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_start <= start_d;
      cap_stop  <= stop_d;
      rd_req    <= req_d;
      wbyte     <= wbyte_d;
      word_buf  <= word_d;
      // byte_cnt counts payload bytes after the command, saturating.
      if (byte_done && (state_q != ST_CMD) && (byte_cnt != 4'hF)) begin
        byte_cnt <= byte_cnt + 4'd1;
      end
      if (mask_cap) begin
        mask_sh <= rx_byte[NUM_CH-1:0];
      end
      if (len_shift) begin
        len_sh <= len_next;
      end
    end
  end

  // Configuration and the sticky underrun survive chip-select cycling.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      ch_mask  <= '1;
      cap_len  <= '0;
      underrun <= 1'b0;
    end else begin
      if (cfg_commit) begin
        ch_mask <= mask_sh;
        cap_len <= len_next;
      end
      if (ur_set) begin
        underrun <= 1'b1;
      end else if (ur_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
